// File: rtl/fp_mant_mult_seq.sv
// Iterative shift-and-add significand multiplier: {1,a_mant} * {1,b_mant} -> 48-bit unrounded product.
// Define FP_MANT_MULT_RADIX4_EN for the radix-4 iteration (half the latency, identical products).
module fp_mant_mult_seq #(
  parameter int MANT_W = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W-1:0]         a_mant,
  input  logic [MANT_W-1:0]         b_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*(MANT_W+1)-1:0]   product,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  localparam int SIG_W  = MANT_W + 1;
  localparam int PROD_W = 2 * SIG_W;
`ifdef FP_MANT_MULT_RADIX4_EN
  localparam int STEPS  = SIG_W / 2;
`else
  localparam int STEPS  = SIG_W;
`endif
  localparam int CNT_W  = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and both are pure state decodes.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SIG_W-1:0]   mcand_q;
  logic [SIG_W-1:0]   mplier_q;
  logic [SIG_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               load;
  logic               step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_dbg = state_q;

`ifdef FP_MANT_MULT_RADIX4_EN
  if ((SIG_W % 2) != 0) begin : g_sig_w_odd
    $error("radix-4 iteration needs an even significand width");
  end

  // 3x multiplicand is formed once at accept so each iteration is a single add.
  logic [SIG_W+1:0] mcand3_q;
  logic [SIG_W+1:0] addend;
  logic [SIG_W+1:0] sum;

  always_comb begin
    case (mplier_q[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, mcand_q};
      2'd2:    addend = {1'b0, mcand_q, 1'b0};
      default: addend = mcand3_q;
    endcase
    sum = {2'b00, acc_q} + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcand3_q <= '0;
    else if (load) mcand3_q <= {2'b00, 1'b1, a_mant} + {1'b0, 1'b1, a_mant, 1'b0};
  end
`else
  logic [SIG_W:0] sum;

  assign sum = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : {SIG_W{1'b0}})};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= {1'b1, a_mant};
      mplier_q <= {1'b1, b_mant};
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      // The carry of the add lands in acc's MSB as {sum,mplier} shifts right.
`ifdef FP_MANT_MULT_RADIX4_EN
      acc_q    <= sum[SIG_W+1:2];
      mplier_q <= {sum[1:0], mplier_q[SIG_W-1:2]};
`else
      acc_q    <= sum[SIG_W:1];
      mplier_q <= {sum[0], mplier_q[SIG_W-1:1]};
`endif
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign product = (state_q == S_DONE) ? {acc_q, mplier_q} : {PROD_W{1'b0}};

endmodule

// File: tb/tb_fp_mant_mult_seq.sv
// Bench for fp_mant_mult_seq: directed vector table, back-pressure/reset sequences, random stream vs a*b model.
module tb_fp_mant_mult_seq;

  localparam int W = 48;
`ifdef FP_MANT_MULT_RADIX4_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif
  localparam int N_RAND = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [22:0]   a_mant = '0;
  logic [22:0]   b_mant = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  product;
  logic          busy;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [22:0]  a;
    logic [22:0]  b;
    logic [W-1:0] exp;
  } vec_t;

  // clock / reset
  always #5 clk = ~clk;

  fp_mant_mult_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_mant(a_mant), .b_mant(b_mant), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [22:0] a, input logic [22:0] b);
    logic [W-1:0] x, y;
    x = {24'd0, 1'b1, a};
    y = {24'd0, 1'b1, b};
    return x * y;
  endfunction

  // driver: called at a negedge; returns just after the accepting edge
  task automatic start_op(input logic [22:0] a, input logic [22:0] b);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_op", in_ready, 1'b1);
    a_mant   = a;
    b_mant   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // counts rising edges after accept until out_valid is seen; ends at a negedge
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("out_valid_seen", out_valid, 1'b1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, out_valid, 1'b0);
    check({name, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    vec_t vecs[6];
    int   edges;
    logic [W-1:0] held;
    int   sent, received, cyc, dup;

    vecs[0] = '{23'h000000, 23'h000000, 48'h4000_0000_0000};
    vecs[1] = '{23'h400000, 23'h400000, 48'h9000_0000_0000};
    vecs[2] = '{23'h7FFFFF, 23'h7FFFFF, 48'hFFFF_FE00_0001};
    vecs[3] = '{23'h000000, 23'h7FFFFF, 48'h7FFF_FF80_0000};
    vecs[4] = '{23'h400000, 23'h000000, 48'h6000_0000_0000};
    vecs[5] = '{23'h000001, 23'h000001, 48'h4000_0100_0001};

    // reset state
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", product, '0);
    check("rst_state", state_dbg, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(edges);
      check($sformatf("latency_%0d", i), edges, LAT);
      check($sformatf("product_%0d", i), product, vecs[i].exp);
      check($sformatf("busy_done_%0d", i), busy, 1'b1);
      handshake($sformatf("hs_%0d", i));
    end

    // back-pressure with in_valid pulses during BUSY and DONE
    start_op(23'h123456, 23'h654321);
    repeat (3) @(negedge clk);
    a_mant = 23'h7FFFFF; b_mant = 23'h7FFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_busy_in_ready", in_ready, 1'b0);
    wait_done(edges);
    held = product;
    check("bp_product", held, ref_mul(23'h123456, 23'h654321));
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2 == 0);
      @(negedge clk);
      check($sformatf("bp_hold_product_%0d", c), product, held);
      check($sformatf("bp_hold_valid_%0d", c), out_valid, 1'b1);
      check($sformatf("bp_hold_in_ready_%0d", c), in_ready, 1'b0);
    end
    in_valid = 1'b0;
    handshake("bp");
    dup = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) dup++;
    end
    check("bp_no_ghost_op", dup, 0);

    // reset in the middle of an iteration
    start_op(23'h2AAAAA, 23'h555555);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_product", product, '0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dup = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) dup++;
    end
    check("midrst_no_product", dup, 0);
    start_op(23'h0F0F0F, 23'h70F0F0);
    wait_done(edges);
    check("postrst_latency", edges, LAT);
    check("postrst_product", product, ref_mul(23'h0F0F0F, 23'h70F0F0));
    handshake("postrst");

    // random stream: scoreboard against the reference model
    sent = 0; received = 0; cyc = 0;
    while (received < N_RAND && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand_unexpected_product", product, '0);
        else check($sformatf("rand_product_%0d", received), product, exp_q.pop_front());
        received++;
      end
      if (in_ready && sent < N_RAND) begin
        a_mant   = 23'($urandom);
        b_mant   = 23'($urandom);
        in_valid = 1'b1;
        exp_q.push_back(ref_mul(a_mant, b_mant));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_received", received, N_RAND);
    dup = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) dup++;
    end
    check("rand_no_duplicate", dup, 0);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
